// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_pkg
// Description : Shared definitions for the machine-mode trap controller:
//               cause codes, FSM state encoding, mstatus bit positions and
//               the mstatus update helpers for trap entry and MRET.
// Revision    : 1.0  initial release
// ============================================================================
package trap_pkg;

    // Synchronous exception cause codes
    localparam logic [31:0] c_cause_inst_misaligned  = 32'd0;
    localparam logic [31:0] c_cause_illegal_inst     = 32'd2;
    localparam logic [31:0] c_cause_ebreak           = 32'd3;
    localparam logic [31:0] c_cause_load_misaligned  = 32'd4;
    localparam logic [31:0] c_cause_store_misaligned = 32'd6;
    localparam logic [31:0] c_cause_ecall            = 32'd11;

    // Interrupt cause codes (bit 31 set marks an interrupt)
    localparam logic [31:0] c_cause_irq_sw    = 32'h8000_0003;
    localparam logic [31:0] c_cause_irq_timer = 32'h8000_0007;
    localparam logic [31:0] c_cause_irq_ext   = 32'h8000_000B;

    // mip / mie bit positions
    localparam int c_mip_sw    = 3;
    localparam int c_mip_timer = 7;
    localparam int c_mip_ext   = 11;

    // mstatus bit positions
    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_REDIR = 2'd2,
        ST_RET   = 2'd3
    } state_t;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode.
    function automatic logic [31:0] f_mstatus_trap(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[c_mstatus_mpie] = m[c_mstatus_mie];
        r[c_mstatus_mie]  = 1'b0;
        r[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b11;
        return r;
    endfunction

    // MRET: restore MIE from MPIE, re-arm MPIE, stay in M-mode.
    function automatic logic [31:0] f_mstatus_ret(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[c_mstatus_mie]  = m[c_mstatus_mpie];
        r[c_mstatus_mpie] = 1'b1;
        r[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b11;
        return r;
    endfunction

endpackage : trap_pkg
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_if
// Description : Bundle between the pipeline/CSR file and trap_ctrl.
//               Pipeline inputs: valid_i, pc_i, inst_i, badaddr_i, the six
//               exception flags, is_mret_i, irq_*_i, mie_i, mstatus_i,
//               exc_ret_addr_i. CSR write port: we_exc_o, mcause_d_o,
//               mepc_d_o, mtval_d_o, mstatus_d_o, mstatus_we_o, mip_d_o,
//               is_int_o, sel_exc_nret_o. Pipeline control: flush_o, busy_o,
//               pc_redirect_o, pc_target_o.
//               slave = trap_ctrl side, master = pipeline/CSR side.
// Revision    : 1.0  initial release
// ============================================================================
interface trap_ctrl_if;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [31:0] badaddr_i;
    logic        e_inst_misaligned_i;
    logic        e_illegal_inst_i;
    logic        e_ebreak_i;
    logic        e_ecall_i;
    logic        e_load_misaligned_i;
    logic        e_store_misaligned_i;
    logic        is_mret_i;
    logic        irq_ext_i;
    logic        irq_timer_i;
    logic        irq_sw_i;
    logic [31:0] mie_i;
    logic [31:0] mstatus_i;
    logic [31:0] exc_ret_addr_i;

    logic        we_exc_o;
    logic [31:0] mcause_d_o;
    logic [31:0] mepc_d_o;
    logic [31:0] mtval_d_o;
    logic [31:0] mstatus_d_o;
    logic        mstatus_we_o;
    logic [31:0] mip_d_o;
    logic        is_int_o;
    logic        sel_exc_nret_o;
    logic        flush_o;
    logic        busy_o;
    logic        pc_redirect_o;
    logic [31:0] pc_target_o;

    modport slave (
        input  valid_i, pc_i, inst_i, badaddr_i,
               e_inst_misaligned_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i,
               e_load_misaligned_i, e_store_misaligned_i, is_mret_i,
               irq_ext_i, irq_timer_i, irq_sw_i, mie_i, mstatus_i,
               exc_ret_addr_i,
        output we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o,
               mstatus_we_o, mip_d_o, is_int_o, sel_exc_nret_o,
               flush_o, busy_o, pc_redirect_o, pc_target_o
    );

    modport master (
        output valid_i, pc_i, inst_i, badaddr_i,
               e_inst_misaligned_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i,
               e_load_misaligned_i, e_store_misaligned_i, is_mret_i,
               irq_ext_i, irq_timer_i, irq_sw_i, mie_i, mstatus_i,
               exc_ret_addr_i,
        input  we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o,
               mstatus_we_o, mip_d_o, is_int_o, sel_exc_nret_o,
               flush_o, busy_o, pc_redirect_o, pc_target_o
    );
endinterface : trap_ctrl_if
`default_nettype wire

// File: rtl/trap_prio.sv
`default_nettype none
// ============================================================================
// Module      : trap_prio
// Description : Combinational trap arbitration. Builds mip from the interrupt
//               lines, decides whether any trap is taken and returns its
//               cause and mtval. Interrupts (ext > sw > timer) beat all
//               exceptions.
// Ports       : i_e_* exception flags, i_irq_* interrupt lines, i_mie,
//               i_mstatus_mie (global enable), i_inst, i_badaddr;
//               o_mip, o_trap, o_is_int, o_cause, o_mtval.
// Revision    : 1.0  initial release
// ============================================================================
module trap_prio
    import trap_pkg::*;
(
    input  wire logic        i_e_inst_misaligned,
    input  wire logic        i_e_illegal_inst,
    input  wire logic        i_e_ebreak,
    input  wire logic        i_e_ecall,
    input  wire logic        i_e_load_misaligned,
    input  wire logic        i_e_store_misaligned,
    input  wire logic        i_irq_ext,
    input  wire logic        i_irq_timer,
    input  wire logic        i_irq_sw,
    input  wire logic [31:0] i_mie,
    input  wire logic        i_mstatus_mie,
    input  wire logic [31:0] i_inst,
    input  wire logic [31:0] i_badaddr,
    output logic      [31:0] o_mip,
    output logic             o_trap,
    output logic             o_is_int,
    output logic      [31:0] o_cause,
    output logic      [31:0] o_mtval
);

    logic [31:0] w_irq_en;
    logic        w_irq_pend;

    always_comb begin
        o_mip             = 32'd0;
        o_mip[c_mip_ext]   = i_irq_ext;
        o_mip[c_mip_timer] = i_irq_timer;
        o_mip[c_mip_sw]    = i_irq_sw;
    end

    assign w_irq_en   = o_mip & i_mie;
    assign w_irq_pend = i_mstatus_mie & (|w_irq_en);

    always_comb begin
        o_trap   = 1'b0;
        o_is_int = 1'b0;
        o_cause  = 32'd0;
        o_mtval  = 32'd0;
        if (w_irq_pend) begin
            o_trap   = 1'b1;
            o_is_int = 1'b1;
            if (w_irq_en[c_mip_ext])     o_cause = c_cause_irq_ext;
            else if (w_irq_en[c_mip_sw]) o_cause = c_cause_irq_sw;
            else                         o_cause = c_cause_irq_timer;
        end else if (i_e_inst_misaligned) begin
            o_trap  = 1'b1;
            o_cause = c_cause_inst_misaligned;
            o_mtval = i_badaddr;
        end else if (i_e_illegal_inst) begin
            o_trap  = 1'b1;
            o_cause = c_cause_illegal_inst;
            o_mtval = i_inst;
        end else if (i_e_ebreak) begin
            o_trap  = 1'b1;
            o_cause = c_cause_ebreak;
        end else if (i_e_ecall) begin
            o_trap  = 1'b1;
            o_cause = c_cause_ecall;
        end else if (i_e_load_misaligned) begin
            o_trap  = 1'b1;
            o_cause = c_cause_load_misaligned;
            o_mtval = i_badaddr;
        end else if (i_e_store_misaligned) begin
            o_trap  = 1'b1;
            o_cause = c_cause_store_misaligned;
            o_mtval = i_badaddr;
        end
    end

endmodule : trap_prio
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. IDLE accepts a trap or MRET from
//               the check stage; TRAP writes mcause/mepc/mtval/mstatus and
//               flushes; REDIR steers fetch to the handler; RET performs
//               MRET. Busy outside IDLE, nothing is queued.
// Ports       : clk_i, rst_i (async, active-low), bus (trap_ctrl_if.slave).
// Parameters  : VECTORED - 1: interrupts target mtvec + 4*cause.
// Revision    : 1.0  initial release
// ============================================================================
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int VECTORED = 0
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    trap_ctrl_if.slave  bus
);

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_mcause;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;
    logic        r_is_int;

    logic        w_trap;
    logic        w_is_int;
    logic [31:0] w_cause;
    logic [31:0] w_mtval;
    logic        w_accept;
    logic [31:0] w_vec_off;

    trap_prio u_prio (
        .i_e_inst_misaligned  (bus.e_inst_misaligned_i),
        .i_e_illegal_inst     (bus.e_illegal_inst_i),
        .i_e_ebreak           (bus.e_ebreak_i),
        .i_e_ecall            (bus.e_ecall_i),
        .i_e_load_misaligned  (bus.e_load_misaligned_i),
        .i_e_store_misaligned (bus.e_store_misaligned_i),
        .i_irq_ext            (bus.irq_ext_i),
        .i_irq_timer          (bus.irq_timer_i),
        .i_irq_sw             (bus.irq_sw_i),
        .i_mie                (bus.mie_i),
        .i_mstatus_mie        (bus.mstatus_i[c_mstatus_mie]),
        .i_inst               (bus.inst_i),
        .i_badaddr            (bus.badaddr_i),
        .o_mip                (bus.mip_d_o),
        .o_trap               (w_trap),
        .o_is_int             (w_is_int),
        .o_cause              (w_cause),
        .o_mtval              (w_mtval)
    );

    assign w_accept = (r_state == ST_IDLE) && bus.valid_i && w_trap;

    // Vector offset applies only to interrupts in vectored mode.
    assign w_vec_off = ((VECTORED != 0) && r_is_int) ?
                       {25'd0, r_mcause[4:0], 2'b00} : 32'd0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // Trap record is captured only on acceptance, so it holds through REDIR.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcause <= 32'd0;
            r_mepc   <= 32'd0;
            r_mtval  <= 32'd0;
            r_is_int <= 1'b0;
        end else if (w_accept) begin
            r_mcause <= w_cause;
            r_mepc   <= bus.pc_i;
            r_mtval  <= w_mtval;
            r_is_int <= w_is_int;
        end
    end

    assign bus.mcause_d_o = r_mcause;
    assign bus.mepc_d_o   = r_mepc;
    assign bus.mtval_d_o  = r_mtval;

    always_comb begin
        w_state_nx         = r_state;
        bus.we_exc_o       = 1'b0;
        bus.mstatus_we_o   = 1'b0;
        bus.mstatus_d_o    = 32'd0;
        bus.is_int_o       = 1'b0;
        bus.sel_exc_nret_o = 1'b0;
        bus.flush_o        = 1'b0;
        bus.busy_o         = 1'b1;
        bus.pc_redirect_o  = 1'b0;
        bus.pc_target_o    = 32'd0;
        case (r_state)
            ST_IDLE: begin
                bus.busy_o = 1'b0;
                if (bus.valid_i && w_trap)          w_state_nx = ST_TRAP;
                else if (bus.valid_i && bus.is_mret_i) w_state_nx = ST_RET;
            end
            ST_TRAP: begin
                bus.we_exc_o     = 1'b1;
                bus.mstatus_we_o = 1'b1;
                bus.mstatus_d_o  = f_mstatus_trap(bus.mstatus_i);
                bus.flush_o      = 1'b1;
                bus.is_int_o     = r_is_int;
                w_state_nx       = ST_REDIR;
            end
            ST_REDIR: begin
                bus.pc_redirect_o = 1'b1;
                bus.pc_target_o   = {bus.exc_ret_addr_i[31:2], 2'b00} + w_vec_off;
                w_state_nx        = ST_IDLE;
            end
            ST_RET: begin
                bus.sel_exc_nret_o = 1'b1;
                bus.flush_o        = 1'b1;
                bus.pc_redirect_o  = 1'b1;
                bus.pc_target_o    = bus.exc_ret_addr_i;
                bus.mstatus_we_o   = 1'b1;
                bus.mstatus_d_o    = f_mstatus_ret(bus.mstatus_i);
                w_state_nx         = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed, table-driven bench for trap_ctrl (VECTORED=1),
//               with hand-written sequences for MRET, masked interrupts,
//               reset during TRAP and inputs arriving while busy.
// Revision    : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   we_pulses;

    trap_ctrl_if bus ();

    trap_ctrl #(.VECTORED(1)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exc bits: {inst_mis, illegal, ebreak, ecall, load_mis, store_mis}
    // irq bits: {ext, timer, sw}
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] badaddr;
        logic [5:0]  exc;
        logic [2:0]  irq;
        logic [31:0] mie;
        logic [31:0] mstatus;
        logic [31:0] ret;
        logic [31:0] e_cause;
        logic [31:0] e_mtval;
        logic [31:0] e_mstatus;
        logic [31:0] e_target;
        logic [31:0] e_mip;
        logic        e_int;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.valid_i              = 1'b0;
        bus.e_inst_misaligned_i  = 1'b0;
        bus.e_illegal_inst_i     = 1'b0;
        bus.e_ebreak_i           = 1'b0;
        bus.e_ecall_i            = 1'b0;
        bus.e_load_misaligned_i  = 1'b0;
        bus.e_store_misaligned_i = 1'b0;
        bus.is_mret_i            = 1'b0;
        bus.irq_ext_i            = 1'b0;
        bus.irq_timer_i          = 1'b0;
        bus.irq_sw_i             = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.valid_i              = 1'b1;
        bus.pc_i                 = v.pc;
        bus.inst_i               = v.inst;
        bus.badaddr_i            = v.badaddr;
        {bus.e_inst_misaligned_i, bus.e_illegal_inst_i, bus.e_ebreak_i,
         bus.e_ecall_i, bus.e_load_misaligned_i, bus.e_store_misaligned_i} = v.exc;
        {bus.irq_ext_i, bus.irq_timer_i, bus.irq_sw_i} = v.irq;
        bus.is_mret_i            = 1'b0;
        bus.mie_i                = v.mie;
        bus.mstatus_i            = v.mstatus;
        bus.exc_ret_addr_i       = v.ret;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        we_pulses = 0;

        //          pc            inst          badaddr       exc       irq     mie           mstatus       ret           cause         mtval         mstatus_d     target        mip           int
        vecs[0]  = '{32'h100,     32'hFFFFFFFF, 32'h0,        6'b010000, 3'b000, 32'h0,        32'h0,        32'h200,      32'h2,        32'hFFFFFFFF, 32'h1800,     32'h200,      32'h0,        1'b0};
        vecs[1]  = '{32'h2000,    32'h00000073, 32'h0,        6'b000100, 3'b010, 32'h80,       32'h8,        32'h400,      32'h80000007, 32'h0,        32'h1880,     32'h41C,      32'h80,       1'b1};
        vecs[2]  = '{32'h3000,    32'h12345678, 32'h1002,     6'b110010, 3'b000, 32'h0,        32'h0,        32'h203,      32'h0,        32'h1002,     32'h1800,     32'h200,      32'h0,        1'b0};
        vecs[3]  = '{32'h3004,    32'h00100073, 32'h55,       6'b001100, 3'b000, 32'h0,        32'h88,       32'h200,      32'h3,        32'h0,        32'h1880,     32'h200,      32'h0,        1'b0};
        vecs[4]  = '{32'h3008,    32'h00000073, 32'h66,       6'b000110, 3'b000, 32'h0,        32'h80,       32'h200,      32'hB,        32'h0,        32'h1800,     32'h200,      32'h0,        1'b0};
        vecs[5]  = '{32'h300C,    32'hAAAA5555, 32'hDEAD0004, 6'b000011, 3'b000, 32'h0,        32'hFFFFFFFF, 32'h200,      32'h4,        32'hDEAD0004, 32'hFFFFFFF7, 32'h200,      32'h0,        1'b0};
        vecs[6]  = '{32'h3010,    32'h0,        32'hBEEF0002, 6'b000001, 3'b000, 32'h0,        32'h0,        32'h200,      32'h6,        32'hBEEF0002, 32'h1800,     32'h200,      32'h0,        1'b0};
        vecs[7]  = '{32'h4000,    32'h0,        32'h0,        6'b000000, 3'b111, 32'hFFFFFFFF, 32'h8,        32'h400,      32'h8000000B, 32'h0,        32'h1880,     32'h42C,      32'h888,      1'b1};
        vecs[8]  = '{32'h4004,    32'h0,        32'h0,        6'b000000, 3'b011, 32'h888,      32'h8,        32'h400,      32'h80000003, 32'h0,        32'h1880,     32'h40C,      32'h88,       1'b1};
        vecs[9]  = '{32'h4008,    32'hFFFF0000, 32'h0,        6'b010000, 3'b110, 32'h80,       32'h8,        32'h400,      32'h80000007, 32'h0,        32'h1880,     32'h41C,      32'h880,      1'b1};
        vecs[10] = '{32'h400C,    32'hCAFEBABE, 32'h0,        6'b010000, 3'b111, 32'h0,        32'h8,        32'h400,      32'h2,        32'hCAFEBABE, 32'h1880,     32'h400,      32'h888,      1'b0};
        vecs[11] = '{32'h4010,    32'h0,        32'h0,        6'b000100, 3'b100, 32'hFFFFFFFF, 32'h0,        32'h400,      32'hB,        32'h0,        32'h1800,     32'h400,      32'h800,      1'b0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        clear_req();
        bus.pc_i = 32'h0; bus.inst_i = 32'h0; bus.badaddr_i = 32'h0;
        bus.mie_i = 32'h0; bus.mstatus_i = 32'h0; bus.exc_ret_addr_i = 32'h0;
        bus.irq_ext_i = 1'b1;
        tick();
        tick();
        chk("rst_we_exc", {31'd0, bus.we_exc_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_mcause", bus.mcause_d_o, 32'd0);
        chk("rst_mstatus_d", bus.mstatus_d_o, 32'd0);
        chk("rst_pc_target", bus.pc_target_o, 32'd0);
        chk("rst_mip", bus.mip_d_o, 32'h800);
        bus.irq_ext_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // ---------------- table-driven trap vectors ----------------
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_mip", i), bus.mip_d_o, vecs[i].e_mip);
            chk($sformatf("v%0d_idle_we", i), {31'd0, bus.we_exc_o}, 32'd0);
            tick();
            clear_req();
            chk($sformatf("v%0d_we_exc", i), {31'd0, bus.we_exc_o}, 32'd1);
            chk($sformatf("v%0d_mcause", i), bus.mcause_d_o, vecs[i].e_cause);
            chk($sformatf("v%0d_mepc", i), bus.mepc_d_o, vecs[i].pc);
            chk($sformatf("v%0d_mtval", i), bus.mtval_d_o, vecs[i].e_mtval);
            chk($sformatf("v%0d_is_int", i), {31'd0, bus.is_int_o}, {31'd0, vecs[i].e_int});
            chk($sformatf("v%0d_mstatus_d", i), bus.mstatus_d_o, vecs[i].e_mstatus);
            chk($sformatf("v%0d_trap_strobes", i),
                {28'd0, bus.mstatus_we_o, bus.flush_o, bus.sel_exc_nret_o, bus.pc_redirect_o}, 32'hC);
            tick();
            chk($sformatf("v%0d_redirect", i),
                {29'd0, bus.pc_redirect_o, bus.we_exc_o, bus.busy_o}, 32'h5);
            chk($sformatf("v%0d_target", i), bus.pc_target_o, vecs[i].e_target);
            chk($sformatf("v%0d_mcause_hold", i), bus.mcause_d_o, vecs[i].e_cause);
            tick();
            chk($sformatf("v%0d_back_idle", i),
                {30'd0, bus.busy_o, bus.pc_redirect_o}, 32'd0);
        end

        // ---------------- MRET ----------------
        bus.valid_i = 1'b1; bus.is_mret_i = 1'b1;
        bus.mstatus_i = 32'h80; bus.exc_ret_addr_i = 32'h344; bus.mie_i = 32'h0;
        tick();
        clear_req();
        chk("mret_sel", {31'd0, bus.sel_exc_nret_o}, 32'd1);
        chk("mret_strobes",
            {28'd0, bus.flush_o, bus.pc_redirect_o, bus.mstatus_we_o, bus.we_exc_o}, 32'hE);
        chk("mret_target", bus.pc_target_o, 32'h344);
        chk("mret_mstatus_d", bus.mstatus_d_o, 32'h1888);
        tick();
        chk("mret_done", {30'd0, bus.busy_o, bus.pc_redirect_o}, 32'd0);

        // ---------------- interrupt with MIE=0 ----------------
        bus.valid_i = 1'b1; bus.irq_ext_i = 1'b1;
        bus.mie_i = 32'hFFFFFFFF; bus.mstatus_i = 32'h0;
        #1;
        chk("mie0_mip", bus.mip_d_o, 32'h800);
        tick();
        chk("mie0_no_strobes",
            {28'd0, bus.we_exc_o, bus.flush_o, bus.pc_redirect_o, bus.busy_o}, 32'd0);
        clear_req();

        // ---------------- exception with valid_i=0 ----------------
        bus.e_illegal_inst_i = 1'b1;
        tick();
        chk("novalid_no_trap", {30'd0, bus.we_exc_o, bus.busy_o}, 32'd0);
        clear_req();

        // ---------------- reset during TRAP ----------------
        bus.valid_i = 1'b1; bus.e_ecall_i = 1'b1; bus.pc_i = 32'h700;
        bus.exc_ret_addr_i = 32'h200;
        tick();
        clear_req();
        chk("rsttrap_in_trap", {31'd0, bus.we_exc_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rsttrap_abandon",
            {28'd0, bus.we_exc_o, bus.flush_o, bus.busy_o, bus.mstatus_we_o}, 32'd0);
        chk("rsttrap_mcause", bus.mcause_d_o, 32'd0);
        tick();
        chk("rsttrap_no_redir", {31'd0, bus.pc_redirect_o}, 32'd0);
        rst_n = 1'b1;
        bus.valid_i = 1'b1; bus.e_ecall_i = 1'b1; bus.pc_i = 32'h704;
        tick();
        clear_req();
        chk("rsttrap_retrap_we", {31'd0, bus.we_exc_o}, 32'd1);
        chk("rsttrap_retrap_cause", bus.mcause_d_o, 32'd11);
        chk("rsttrap_retrap_mepc", bus.mepc_d_o, 32'h704);
        tick();
        tick();

        // ---------------- second exception while busy ----------------
        bus.valid_i = 1'b1; bus.e_illegal_inst_i = 1'b1;
        bus.pc_i = 32'h500; bus.inst_i = 32'h0BADC0DE;
        tick();
        if (bus.we_exc_o) we_pulses++;
        bus.e_illegal_inst_i = 1'b0; bus.e_ecall_i = 1'b1; bus.pc_i = 32'h600;
        chk("busy_first_cause", bus.mcause_d_o, 32'd2);
        tick();
        if (bus.we_exc_o) we_pulses++;
        chk("busy_mepc_hold", bus.mepc_d_o, 32'h500);
        chk("busy_mtval_hold", bus.mtval_d_o, 32'h0BADC0DE);
        tick();
        if (bus.we_exc_o) we_pulses++;
        clear_req();
        tick();
        if (bus.we_exc_o) we_pulses++;
        tick();
        if (bus.we_exc_o) we_pulses++;
        chk("busy_we_pulses", we_pulses, 32'd1);
        chk("busy_final_idle", {31'd0, bus.busy_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_trap_ctrl
`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter VECTORED, default 0, meaning: 1 = interrupts target mtvec_base + 4*cause; 0 = all traps target mtvec_base.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i  in  1  instruction in the trap-check stage is valid.
REQ-005 SHALL have port pc_i  in  32  PC of that instruction.
REQ-006 SHALL have port inst_i  in  32  raw instruction word.
REQ-007 SHALL have port badaddr_i  in  32  faulting fetch or load/store address.
REQ-008 SHALL have ports e_inst_misaligned_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i, e_load_misaligned_i, e_store_misaligned_i  in  1 each  synchronous exception flags.
REQ-009 SHALL have port is_mret_i  in  1  instruction is MRET.
REQ-010 SHALL have ports irq_ext_i, irq_timer_i, irq_sw_i  in  1 each  level interrupt requests.
REQ-011 SHALL have ports mie_i  in  32  (CSR mie), and mstatus_i  in  32  (CSR mstatus).
REQ-012 SHALL have port exc_ret_addr_i  in  32  mepc when sel_exc_nret_o=1, else mtvec.
REQ-013 SHALL have outputs we_exc_o 1, mcause_d_o 32, mepc_d_o 32, mtval_d_o 32, mstatus_d_o 32, mstatus_we_o 1, mip_d_o 32, is_int_o 1, sel_exc_nret_o 1: the CSR-side write port.
REQ-014 SHALL have outputs flush_o 1, busy_o 1, pc_redirect_o 1, pc_target_o 32: the pipeline side.

Function
REQ-015 SHALL drive mip_d_o every cycle as bit11=irq_ext_i, bit7=irq_timer_i, bit3=irq_sw_i, other bits 0.
REQ-016 SHALL treat an interrupt as pending when mstatus_i[3]=1 and (mip_d_o & mie_i)!=0; priority ext(11) > sw(3) > timer(7).
REQ-017 SHALL use exception priority inst_misaligned(0) > illegal(2) > ebreak(3) > ecall(11) > load_misaligned(4) > store_misaligned(6).
REQ-018 SHALL, in IDLE with valid_i=1, take a pending interrupt in preference to any exception or MRET on the same instruction.
REQ-019 SHALL, on trap entry, latch mepc=pc_i and mcause (bit31=1 for interrupts), plus mtval: badaddr_i for cause 0/4/6, inst_i for cause 2, else 0.
REQ-020 SHALL implement FSM states IDLE, TRAP, REDIR, RET.
REQ-021 SHALL transition IDLE->TRAP on an accepted trap, IDLE->RET on is_mret_i with no trap, TRAP->REDIR, REDIR->IDLE, RET->IDLE.
REQ-022 SHALL, in TRAP (exactly one cycle), assert we_exc_o=1, mstatus_we_o=1, flush_o=1, sel_exc_nret_o=0, and is_int_o=1 iff an interrupt was taken.
REQ-023 SHALL, in TRAP, set mstatus_d_o = mstatus_i with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11.
REQ-024 SHALL, in REDIR, assert pc_redirect_o=1 with pc_target_o = {exc_ret_addr_i[31:2],2'b00}, plus 4*cause[4:0] when VECTORED=1 and the trap was an interrupt.
REQ-025 SHALL, in RET, assert sel_exc_nret_o=1, flush_o=1, pc_redirect_o=1, pc_target_o=exc_ret_addr_i, mstatus_we_o=1, and mstatus_d_o with MIE=MPIE, MPIE=1, MPP=2'b11.
REQ-026 SHALL hold busy_o=1 in every state except IDLE; inputs sampled outside IDLE are ignored, and nothing is queued.
REQ-027 SHALL keep all CSR and pipeline strobes at 0 in IDLE and whenever valid_i=0; trap entry latency is one cycle from the accepted input to we_exc_o, and two cycles to pc_redirect_o.
REQ-028 SHALL keep mcause/mepc/mtval data outputs stable from TRAP through REDIR.

Reset
REQ-029 SHALL, on rst_i=0, enter IDLE immediately, including mid-TRAP, mid-REDIR or mid-RET, and abandon the operation with no further strobes.
REQ-030 SHALL drive all outputs 0 and all latched registers 0 during reset, except mip_d_o, which stays combinational.

Structure
REQ-031 SHALL place cause codes, the FSM state encoding and mstatus bit positions (MIE=3, MPIE=7, MPP=12:11) in shared package trap_pkg.
REQ-032 SHALL implement the priority selection of cause and mtval in one combinational sub-module, trap_prio.

Verification
REQ-033 SHALL cover: e_illegal_inst_i=1, pc_i=0x100, inst_i=0xFFFFFFFF, mtvec=0x200 -> next cycle we_exc_o=1, mcause_d_o=2, mepc_d_o=0x100, mtval_d_o=0xFFFFFFFF; the cycle after, pc_target_o=0x200.
REQ-034 SHALL cover: irq_timer_i=1, mie_i=0x80, mstatus_i=0x8, VECTORED=1, mtvec=0x400, with e_ecall_i=1 on the same instruction -> mcause_d_o=0x80000007, is_int_o=1, mstatus_d_o MIE=0/MPIE=1, pc_target_o=0x41C.
REQ-035 SHALL cover: is_mret_i=1, mepc=0x344, mstatus_i=0x80 -> sel_exc_nret_o=1, pc_target_o=0x344, mstatus_d_o[3]=1, mstatus_d_o[7]=1.
REQ-036 SHALL cover: irq_ext_i=1 with mstatus_i[3]=0 -> no strobes, busy_o=0, mip_d_o=0x800.
REQ-037 SHALL cover: e_ecall_i in IDLE, then rst_i=0 during TRAP -> IDLE in the same cycle, no pc_redirect_o; after release, a new ecall traps with mcause_d_o=11.
REQ-038 SHALL cover: a second exception presented while busy_o=1 -> ignored, only one we_exc_o pulse.
